// File: rtl/sift_pkg.sv
// Shared image geometry and loader state encoding for the SIFT core.
// The blur and detect stages use the same image constants.
package sift_pkg;

    localparam int IMG_W         = 640;
    localparam int IMG_H         = 480;
    localparam int PIX_W         = 8;
    localparam int BEAT_W        = 16;
    localparam int ADDR_W        = 9;
    localparam int ROW_BITS      = IMG_W * PIX_W;
    localparam int BEATS_PER_ROW = ROW_BITS / BEAT_W;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/img_row_loader_if.sv
// Pixel beat stream into the row loader plus its row-wide SRAM write port.
// The loader takes the slave side; the stream source / SRAM take the master side.
interface img_row_loader_if #(
    parameter int BEAT_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int ROW_BITS = 5120
);

    logic                in_valid;
    logic [BEAT_W-1:0]   in_data;
    logic                in_ready;
    logic                img_we;
    logic [ADDR_W-1:0]   img_addr;
    logic [ROW_BITS-1:0] img_din;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  img_we,
        input  img_addr,
        input  img_din
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output img_we,
        output img_addr,
        output img_din
    );

endinterface

// File: rtl/img_row_loader.sv
// Packs a two-pixels-per-beat greyscale stream into full-row words and writes
// each completed row to the original-image SRAM, pulsing done after the last row.
module img_row_loader
    import sift_pkg::*;
#(
    parameter int IMG_W  = sift_pkg::IMG_W,
    parameter int IMG_H  = sift_pkg::IMG_H,
    parameter int PIX_W  = sift_pkg::PIX_W,
    parameter int BEAT_W = sift_pkg::BEAT_W,
    parameter int ADDR_W = sift_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    img_row_loader_if.slave  bus,
    output logic             busy,
    output logic             done
);

    localparam int ROW_W  = IMG_W * PIX_W;
    localparam int BEATS  = ROW_W / BEAT_W;
    localparam int BCNT_W = 9;

    loader_state_e      state_q, state_d;
    logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]  row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]   row_buf_q, row_buf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            row_buf_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_buf_q  <= row_buf_d;
        end
    end

    // Outputs decode only the registered state, so img_we and done cannot glitch.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        row_cnt_d    = row_cnt_q;
        row_buf_d    = row_buf_q;
        bus.in_ready = 1'b0;
        bus.img_we   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d    = LD_RECV;
                    beat_cnt_d = '0;
                    row_cnt_d  = '0;
                end
            end
            LD_RECV: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    // Oldest beat drifts toward the MSB end, giving an MSB-first pixel order.
                    row_buf_d = {row_buf_q[ROW_W-BEAT_W-1:0], bus.in_data};
                    if (beat_cnt_q == BCNT_W'(BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = LD_WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            LD_WRITE: begin
                bus.img_we = 1'b1;
                if (row_cnt_q == ADDR_W'(IMG_H - 1)) begin
                    state_d = LD_DONE;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = LD_RECV;
                end
            end
            LD_DONE: begin
                done    = 1'b1;
                state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    assign bus.img_addr = row_cnt_q;
    assign bus.img_din  = row_buf_q;

endmodule

// File: tb/tb_img_row_loader.sv
// Self-checking bench for img_row_loader on a reduced 128x24 frame, with a
// pixel-level image model and an SRAM capture array.
module tb_img_row_loader;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 24;
    localparam int PIX_W  = 8;
    localparam int BEAT_W = 16;
    localparam int ADDR_W = 9;
    localparam int ROW_W  = IMG_W * PIX_W;
    localparam int BEATS  = ROW_W / BEAT_W;
    localparam int TOTAL  = IMG_H * BEATS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    logic [ROW_W-1:0] mem [IMG_H];
    int               wr_cnt [IMG_H];

    always #5 clk = ~clk;

    img_row_loader_if #(.BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .ROW_BITS(ROW_W)) bus ();

    img_row_loader #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W),
        .BEAT_W(BEAT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .bus  (bus.slave),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Row r of the test image: even pixels carry the row number, odd pixels the beat index.
    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] w;
        logic [7:0]       pix;
        w = '0;
        for (int p = 0; p < IMG_W; p++) begin
            pix = (p % 2 == 0) ? 8'(r) : 8'(p / 2);
            w[ROW_W-1-PIX_W*p -: PIX_W] = pix;
        end
        return w;
    endfunction

    function automatic logic [BEAT_W-1:0] beat_data(input int idx);
        return {8'(idx / BEATS), 8'(idx % BEATS)};
    endfunction

    task automatic check_row(input string tag, input int r);
        logic [ROW_W-1:0] e;
        int               bad;
        e   = exp_row(r);
        bad = -1;
        for (int p = 0; p < IMG_W; p++)
            if (bad < 0 && mem[r][ROW_W-1-PIX_W*p -: PIX_W] !== e[ROW_W-1-PIX_W*p -: PIX_W]) bad = p;
        if (bad < 0) bad = 0;
        checks++;
        assert (mem[r] === e) else begin
            failures++;
            $error("FAIL %s row %0d pixel %0d: got 0x%0h want 0x%0h", tag, r, bad,
                   mem[r][ROW_W-1-PIX_W*bad -: PIX_W], e[ROW_W-1-PIX_W*bad -: PIX_W]);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_img_we"}, bus.img_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_img_addr"}, bus.img_addr, 0);
        check({tag, "_img_din_zero"}, bus.img_din == '0, 1);
    endtask

    // Streams one frame with a holding source. duty = % chance of offering a new beat.
    // poke_row >= 0 pulses start during that row's write; abort_idx >= 0 resets mid-frame
    // once that many beats have been accepted.
    task automatic run_frame(input string tag, input int duty, input int poke_row,
                             input bit start_on_done, input int abort_idx);
        int idx, cyc, nwr, ndone, done_cyc, post;
        bit ready_prev, acc;
        for (int r = 0; r < IMG_H; r++) begin
            wr_cnt[r] = 0;
            mem[r]    = '0;
        end
        idx = 0; cyc = 0; nwr = 0; ndone = 0; done_cyc = -1; post = 0;
        @(negedge clk);
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = beat_data(0);
        ready_prev   = 1'b0;
        while (post < 3 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            acc   = bus.in_valid && ready_prev;
            if (acc) idx++;
            if (abort_idx >= 0 && idx == abort_idx) break;
            ready_prev = bus.in_ready;
            if (bus.img_we) begin
                check({tag, "_wr_addr"}, bus.img_addr, nwr);
                check({tag, "_beats_at_wr"}, idx, (nwr + 1) * BEATS);
                check({tag, "_ready_in_wr"}, bus.in_ready, 0);
                if (bus.img_addr < IMG_H) begin
                    mem[bus.img_addr]    = bus.img_din;
                    wr_cnt[bus.img_addr] = wr_cnt[bus.img_addr] + 1;
                end
                if (bus.img_addr == poke_row) start = 1'b1;
                nwr++;
            end
            if (done_cyc >= 0) begin
                post++;
                check({tag, "_idle_after_done"}, busy, 0);
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                check({tag, "_busy_in_done"}, busy, 1);
                check({tag, "_ready_in_done"}, bus.in_ready, 0);
                if (start_on_done) start = 1'b1;
            end
            if (!bus.in_valid || acc) begin
                bus.in_valid = (idx < TOTAL) && ($urandom_range(0, 99) < duty);
                bus.in_data  = bus.in_valid ? beat_data(idx) : BEAT_W'($urandom);
            end
        end
        if (abort_idx >= 0) begin
            rst_n        = 1'b0;
            bus.in_valid = 1'b1;
            repeat (2) @(negedge clk);
            check_idle_reset({tag, "_rst"});
            check({tag, "_rows_before_rst"}, nwr, abort_idx / BEATS);
            check({tag, "_no_partial_wr"}, wr_cnt[abort_idx / BEATS], 0);
            rst_n        = 1'b1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            check({tag, "_idle_after_rst"}, busy, 0);
        end else begin
            check({tag, "_done_seen"}, done_cyc >= 0, 1);
            check({tag, "_done_count"}, ndone, 1);
            check({tag, "_writes"}, nwr, IMG_H);
            check({tag, "_beats"}, idx, TOTAL);
            if (duty >= 100) check({tag, "_done_latency"}, done_cyc, IMG_H * (BEATS + 1) + 1);
            for (int r = 0; r < IMG_H; r++) begin
                check({tag, "_wr_once"}, wr_cnt[r], 1);
                check_row(tag, r);
            end
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hA5A5;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("reset_release_idle", busy, 0);

        run_frame("cont", 100, -1, 1'b1, -1);
        check("cont_row5_first", mem[5][ROW_W-1 -: 16], 16'h0500);
        check("cont_row5_last", mem[5][15:0], 16'h053F);
        check("cont_row1_beat0", mem[1][ROW_W-1 -: 16], 16'h0100);

        run_frame("bubbles", 40, -1, 1'b0, -1);

        run_frame("poke", 100, IMG_H / 2, 1'b0, -1);

        run_frame("abort", 100, -1, 1'b0, 3 * BEATS + BEATS / 2);

        run_frame("reload", 100, -1, 1'b0, -1);
        check("reload_row3_first", mem[3][ROW_W-1 -: 16], 16'h0300);
        check("reload_row0_first", mem[0][ROW_W-1 -: 16], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
